twiddle_gen: RTL and testbench



---
 rtl/twiddle_gen.sv | 161 ++++++++++++++++
 tb/tb_twiddle_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// twiddle_gen: full-circle twiddle factor W = cos(2*pi*k/N) - j*sin(2*pi*k/N)
// built from a quarter-wave cosine ROM by quadrant folding. Results are signed
// Q1.(FFT_DW-1) and are returned over a valid/ready handshake.
// Optional macro TWG_INVERSE_EN adds req_inv, which selects the conjugate twiddle.
module twiddle_gen #(
  parameter int FFT_LENGTH = 8192,
  parameter int FFT_DW     = 16,
  parameter int FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FFT_N-1:0]  req_k,
`ifdef TWG_INVERSE_EN
  input  logic              req_inv,
`endif
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [FFT_DW-1:0] tw_re,
  output logic [FFT_DW-1:0] tw_im,
  output logic              twact,
  output logic [FFT_N-3:0]  twa,
  input  logic [FFT_DW-1:0] twdr_cos
);

  typedef enum logic [2:0] {IDLE, RD_C, RD_S, CAP, OUT} state_e;

  localparam logic signed [FFT_DW:0] MAX_POS = {2'b00, {(FFT_DW-1){1'b1}}};
  localparam logic signed [FFT_DW:0] MIN_NEG = {2'b11, {(FFT_DW-1){1'b0}}};

  state_e              state_q, state_d;
  logic [FFT_N-1:0]    k_q, k_d;
  logic [FFT_DW-1:0]   c_q, c_d;
  logic [FFT_N-3:0]    twa_q, twa_d;
  logic [FFT_DW-1:0]   re_q, re_d;
  logic [FFT_DW-1:0]   im_q, im_d;
  logic                inv_q, inv_d;

  logic [1:0]          quad;
  logic [FFT_N-3:0]    r;
  logic                r_zero;
  logic [FFT_DW-1:0]   s_cur;
  logic [FFT_DW-1:0]   cos_mag, sin_mag;
  logic                cos_neg, sin_neg, im_neg;

  assign quad   = k_q[FFT_N-1:FFT_N-2];
  assign r      = k_q[FFT_N-3:0];
  assign r_zero = (r == '0);
  // sin of the folded angle is exactly zero at r=0; the ROM is not read then.
  assign s_cur  = r_zero ? '0 : twdr_cos;

  // Extend an unsigned magnitude by one bit, apply the sign, clamp to the word range.
  function automatic logic [FFT_DW-1:0] apply_sign(input logic [FFT_DW-1:0] mag,
                                                   input logic neg);
    logic signed [FFT_DW:0] v;
    v = $signed({1'b0, mag});
    if (neg) v = -v;
    if (v > MAX_POS) return MAX_POS[FFT_DW-1:0];
    if (v < MIN_NEG) return MIN_NEG[FFT_DW-1:0];
    return v[FFT_DW-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed five-step walk, handshakes only in IDLE and OUT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = RD_C;
      RD_C:    state_d = RD_S;
      RD_S:    state_d = CAP;
      CAP:     state_d = OUT;
      OUT:     if (tw_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and ROM-enable outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE);
    tw_valid  = (state_q == OUT);
    twact     = (state_q == RD_C) || ((state_q == RD_S) && !r_zero);
  end

  // Quadrant folding: pick magnitudes and signs for cos and sin.
  always_comb begin
    cos_mag = c_q;
    sin_mag = s_cur;
    cos_neg = 1'b0;
    sin_neg = 1'b0;
    unique case (quad)
      2'd0: begin cos_mag = c_q;   sin_mag = s_cur;                 end
      2'd1: begin cos_mag = s_cur; sin_mag = c_q;   cos_neg = 1'b1; end
      2'd2: begin cos_mag = c_q;   sin_mag = s_cur; cos_neg = 1'b1; sin_neg = 1'b1; end
      default: begin cos_mag = s_cur; sin_mag = c_q; sin_neg = 1'b1; end
    endcase
`ifdef TWG_INVERSE_EN
    im_neg = inv_q ? sin_neg : !sin_neg;
`else
    im_neg = !sin_neg;
`endif
  end

  // Datapath next values: request capture, ROM addressing, C capture, result.
  always_comb begin
    k_d   = k_q;
    inv_d = inv_q;
    twa_d = twa_q;
    c_d   = c_q;
    re_d  = re_q;
    im_d  = im_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        k_d   = req_k;
`ifdef TWG_INVERSE_EN
        inv_d = req_inv;
`else
        inv_d = 1'b0;
`endif
        twa_d = req_k[FFT_N-3:0];
      end
      // N/4 - r computed modulo the address width; r=0 is excluded so it never wraps to N/4.
      RD_C: if (!r_zero) twa_d = '0 - r;
      RD_S: c_d = twdr_cos;
      CAP: begin
        re_d = apply_sign(cos_mag, cos_neg);
        im_d = apply_sign(sin_mag, im_neg);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      inv_q <= 1'b0;
      twa_q <= '0;
      c_q   <= '0;
      re_q  <= '0;
      im_q  <= '0;
    end else begin
      k_q   <= k_d;
      inv_q <= inv_d;
      twa_q <= twa_d;
      c_q   <= c_d;
      re_q  <= re_d;
      im_q  <= im_d;
    end
  end

  assign twa   = twa_q;
  assign tw_re = re_q;
  assign tw_im = im_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: quarter-wave cosine ROM model plus a reference that
// evaluates cos/sin of the full angle directly and rounds/saturates the result.
module tb_twiddle_gen;

  localparam int N  = 8192;
  localparam int DW = 16;
  localparam int QN = N / 4;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [12:0]   req_k = '0;
  logic          req_inv = 1'b0;
  logic          tw_valid;
  logic          tw_ready = 1'b0;
  logic [DW-1:0] tw_re, tw_im;
  logic          twact;
  logic [10:0]   twa;
  logic [DW-1:0] twdr_cos;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] rom [QN];
  int            rd_log[$];

  int checks = 0;
  int errors = 0;

  twiddle_gen #(.FFT_LENGTH(N), .FFT_DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k),
`ifdef TWG_INVERSE_EN
    .req_inv(req_inv),
`endif
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
    .twact(twact), .twa(twa), .twdr_cos(twdr_cos)
  );

  always #5 clk = ~clk;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int sat(int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: W = cos(th) -/+ j sin(th) evaluated on the full circle.
  task automatic model(input int k, input bit inv, output int re, output int im);
    real th;
    th = 2.0 * PI * real'(k) / real'(N);
    re = sat(rnd($cos(th) * 32768.0));
    im = sat(rnd((inv ? 1.0 : -1.0) * $sin(th) * 32768.0));
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < QN; i++)
      rom[i] = DW'(rnd($cos(2.0 * PI * real'(i) / real'(N)) * 32768.0));
  end

  // ROM: address latched on a twact edge, data presented the following cycle.
  always @(posedge clk) begin
    if (twact) begin
      rom_q <= rom[twa];
      rd_log.push_back(int'(twa));
    end
  end
  assign twdr_cos = rom_q;

  // One full transaction; hold = cycles tw_ready stays low once tw_valid is up,
  // poke = keep offering a new request during that hold.
  task automatic run_txn(input int k, input bit inv, input int hold, input bit poke,
                         output int re, output int im);
    int e, exp_re, exp_im, r, nrd;
    bit inv_eff;
`ifdef TWG_INVERSE_EN
    inv_eff = inv;
`else
    inv_eff = 1'b0;
`endif
    r = k % QN;
    @(negedge clk);
    rd_log.delete();
    req_valid = 1'b1;
    req_k     = 13'(k);
    req_inv   = inv;
    check("req_ready_idle", int'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e = 1;  // the acceptance edge is edge 1
    while (!tw_valid && e < 12) begin
      @(posedge clk);
      #1;
      e++;
    end
    check("latency", e, 4);
    model(k, inv_eff, exp_re, exp_im);
    re = int'($signed(tw_re));
    im = int'($signed(tw_im));
    check("tw_re", re, exp_re);
    check("tw_im", im, exp_im);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (poke) begin
        req_valid = 1'b1;
        req_k     = 13'($urandom);
      end
      check("hold_valid", int'(tw_valid), 1);
      check("hold_req_ready", int'(req_ready), 0);
      check("hold_re", int'($signed(tw_re)), exp_re);
      check("hold_im", int'($signed(tw_im)), exp_im);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tw_ready  = 1'b1;
    @(posedge clk);
    #1;
    tw_ready = 1'b0;
    check("done_valid", int'(tw_valid), 0);
    check("done_req_ready", int'(req_ready), 1);
    nrd = (r == 0) ? 1 : 2;
    check("rd_count", rd_log.size(), nrd);
    if (rd_log.size() > 0) check("rd_addr0", rd_log[0], r);
    if (nrd == 2 && rd_log.size() > 1) check("rd_addr1", rd_log[1], QN - r);
  endtask

  initial begin
    int re, im, re1, im1, re2, im2, k;
    #2;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_tw_valid", int'(tw_valid), 0);
    check("rst_twact", int'(twact), 0);
    check("rst_twa", int'(twa), 0);
    check("rst_tw_re", int'(tw_re), 0);
    check("rst_tw_im", int'(tw_im), 0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(0, 0, 0, 0, re, im);
    check("k0_re", re, 32767);
    check("k0_im", im, 0);
    run_txn(2048, 0, 1, 0, re, im);
    check("k2048_re", re, 0);
    check("k2048_im", im, -32768);
    run_txn(4096, 0, 0, 0, re, im);
    check("k4096_re", re, -32768);
    check("k4096_im", im, 0);
    run_txn(6144, 0, 2, 0, re, im);
    check("k6144_re", re, 0);
    check("k6144_im", im, 32767);
    run_txn(1024, 0, 0, 0, re, im);
    check("k1024_re", re, 23170);
    check("k1024_im", im, -23170);
    run_txn(7168, 0, 0, 0, re, im);
    check("k7168_re", re, 23170);
    check("k7168_im", im, 23170);

    run_txn(5, 0, 6, 1, re1, im1);
    run_txn(8187, 0, 6, 1, re2, im2);
    check("conj_re", re2, re1);
    check("conj_im", im2, -im1);

    // Reset asserted while the block sits in RD_S.
    @(negedge clk);
    req_valid = 1'b1;
    req_k     = 13'd1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tw_valid", int'(tw_valid), 0);
    check("midrst_twact", int'(twact), 0);
    check("midrst_req_ready", int'(req_ready), 1);
    rd_log.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_valid", int'(tw_valid), 0);
    check("midrst_no_reads", rd_log.size(), 0);
    run_txn(3000, 0, 1, 0, re, im);

    run_txn(1, 0, 0, 0, re, im);
    run_txn(2047, 0, 0, 0, re, im);
    run_txn(8191, 0, 1, 0, re, im);

`ifdef TWG_INVERSE_EN
    run_txn(1024, 1, 0, 0, re, im);
    check("inv_k1024_im", im, 23170);
`endif

    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 0) k = int'($urandom_range(0, 3)) * QN;
      else            k = int'($urandom_range(0, N - 1));
      run_txn(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), re, im);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
